// File: rtl/in_out_control_if.sv
// Front-panel / memory-side signal bundle for the I/O sequencer.
interface in_out_control_if;
  logic        key0_pulse;
  logic        key1_pulse;
  logic [8:0]  sw;
  logic        memDone;
  logic [15:0] read_data;
  logic [1:0]  modeOutput;
  logic [24:0] memoryAddress;
  logic [15:0] writeData;
  logic [15:0] displayData;
  logic        ioDone;
  logic [12:0] out_state;

  modport master (
    input  key0_pulse, key1_pulse, sw, memDone, read_data,
    output modeOutput, memoryAddress, writeData, displayData, ioDone, out_state
  );

  modport slave (
    output key0_pulse, key1_pulse, sw, memDone, read_data,
    input  modeOutput, memoryAddress, writeData, displayData, ioDone, out_state
  );
endinterface

// File: rtl/in_out_control.sv
// Key/switch driven sequencer: assembles address/data byte-wise, issues a
// read or write request to the memory controller and reports completion.
module in_out_control (
  input  logic                 clk,
  input  logic                 reset,
  in_out_control_if.master     io
);
  typedef enum logic [3:0] {
    INIT, IDLE, READ_ST0, READ_ST1, READ_ST2, READ_WAIT, READ_DONE,
    WRITE_ST0, WRITE_ST1, WRITE_ST2, WRITE_ST3, WRITE_ST4, WRITE_WAIT
  } state_t;

  state_t      state, state_next;
  logic [24:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] disp_q;
  logic        armed_q;
  logic        wr_pulse_q;

  logic abort, key0_only, key1_only, in_wait;
  assign abort     = io.key0_pulse & io.key1_pulse;
  assign key0_only = io.key0_pulse & ~io.key1_pulse;
  assign key1_only = io.key1_pulse & ~io.key0_pulse;
  assign in_wait   = (state == READ_WAIT) || (state == WRITE_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      INIT:       ;
      IDLE:       if (key0_only) state_next = io.sw[8] ? WRITE_ST0 : READ_ST0;
      READ_ST0:   if (key1_only) state_next = READ_ST1;
      READ_ST1:   if (key1_only) state_next = READ_ST2;
      READ_ST2:   if (key1_only) state_next = READ_WAIT;
      READ_WAIT:  if (armed_q && io.memDone) state_next = READ_DONE;
      READ_DONE:  if (key0_only) state_next = IDLE;
      WRITE_ST0:  if (key1_only) state_next = WRITE_ST1;
      WRITE_ST1:  if (key1_only) state_next = WRITE_ST2;
      WRITE_ST2:  if (key1_only) state_next = WRITE_ST3;
      WRITE_ST3:  if (key1_only) state_next = WRITE_ST4;
      WRITE_ST4:  if (key1_only) state_next = WRITE_WAIT;
      WRITE_WAIT: if (armed_q && io.memDone) state_next = IDLE;
      default:    state_next = INIT;
    endcase
    if (abort) state_next = IDLE;
  end

  // armed_q is low during the first WAIT cycle, enforcing the 2-cycle dwell
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      disp_q     <= '0;
      armed_q    <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      armed_q    <= in_wait && (state_next == state);
      wr_pulse_q <= (state == WRITE_WAIT) && (state_next == IDLE) && !abort;
      if (key1_only) begin
        unique case (state)
          READ_ST0, WRITE_ST0: addr_q[7:0]   <= io.sw[7:0];
          READ_ST1, WRITE_ST1: addr_q[15:8]  <= io.sw[7:0];
          READ_ST2, WRITE_ST2: addr_q[24:16] <= io.sw[8:0];
          WRITE_ST3:           wdata_q[7:0]  <= io.sw[7:0];
          WRITE_ST4:           wdata_q[15:8] <= io.sw[7:0];
          default: ;
        endcase
      end
      if ((state == READ_WAIT) && (state_next == READ_DONE))
        disp_q <= io.read_data;
    end
  end

  assign io.modeOutput    = (state == READ_WAIT)  ? 2'b01 :
                            (state == WRITE_WAIT) ? 2'b10 : 2'b00;
  assign io.ioDone        = (state == READ_DONE) || wr_pulse_q;
  assign io.memoryAddress = addr_q;
  assign io.writeData     = wdata_q;
  assign io.displayData   = disp_q;
  assign io.out_state     = 13'd1 << state;
endmodule

// File: tb/tb_in_out_control.sv
// Directed bench for in_out_control: read, write, abort, ignored keys, async reset.
module tb_in_out_control;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  in_out_control_if io ();

  in_out_control dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive keys for exactly one rising edge, return at the following negedge.
  task automatic press(input logic k0, input logic k1, input logic [8:0] s);
    @(negedge clk);
    io.key0_pulse = k0;
    io.key1_pulse = k1;
    io.sw         = s;
    @(negedge clk);
    io.key0_pulse = 1'b0;
    io.key1_pulse = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    io.key0_pulse = 1'b0;
    io.key1_pulse = 1'b0;
    io.sw         = '0;
    io.memDone    = 1'b0;
    io.read_data  = '0;
    reset = 1'b1;
    #12;
    check("rst_state", 32'(io.out_state), 32'h001);
    check("rst_mode",  32'(io.modeOutput), 32'h0);
    check("rst_addr",  32'(io.memoryAddress), 32'h0);
    check("rst_disp",  32'(io.displayData), 32'h0);
    check("rst_done",  32'(io.ioDone), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    press(1'b1, 1'b1, 9'h000);
    check("init_to_idle", 32'(io.out_state), 32'h002);
    press(1'b0, 1'b1, 9'h000);
    check("idle_key1_ign", 32'(io.out_state), 32'h002);

    // read flow
    press(1'b1, 1'b0, 9'h000);
    check("rd_st0", 32'(io.out_state), 32'h004);
    press(1'b0, 1'b1, 9'h0FF);
    check("rd_st1", 32'(io.out_state), 32'h008);
    press(1'b0, 1'b1, 9'h0FF);
    check("rd_st2", 32'(io.out_state), 32'h010);
    check("rd_addr16", 32'(io.memoryAddress), 32'h000FFFF);
    press(1'b1, 1'b0, 9'h000);
    check("rd_st2_key0_ign", 32'(io.out_state), 32'h010);
    press(1'b0, 1'b1, 9'h1FF);
    check("rd_wait", 32'(io.out_state), 32'h020);
    check("rd_addr", 32'(io.memoryAddress), 32'h1FFFFFF);
    check("rd_mode", 32'(io.modeOutput), 32'h1);
    repeat (3) @(negedge clk);
    check("rd_wait_hold", 32'(io.out_state), 32'h020);
    check("rd_wait_mode", 32'(io.modeOutput), 32'h1);
    io.read_data = 16'hAAAA;
    io.memDone   = 1'b1;
    @(negedge clk);
    io.memDone   = 1'b0;
    check("rd_done", 32'(io.out_state), 32'h040);
    check("rd_disp", 32'(io.displayData), 32'hAAAA);
    check("rd_iodone", 32'(io.ioDone), 32'h1);
    check("rd_done_mode", 32'(io.modeOutput), 32'h0);
    io.read_data = 16'h1234;
    press(1'b1, 1'b0, 9'h000);
    check("rd_ack_idle", 32'(io.out_state), 32'h002);
    check("rd_disp_hold", 32'(io.displayData), 32'hAAAA);
    check("rd_ack_iodone", 32'(io.ioDone), 32'h0);

    // write flow, memDone already high before WAIT to exercise the dwell
    press(1'b1, 1'b0, 9'h100);
    check("wr_st0", 32'(io.out_state), 32'h080);
    press(1'b0, 1'b1, 9'h0FF);
    check("wr_st1", 32'(io.out_state), 32'h100);
    press(1'b0, 1'b1, 9'h0FF);
    check("wr_st2", 32'(io.out_state), 32'h200);
    press(1'b0, 1'b1, 9'h1FF);
    check("wr_st3", 32'(io.out_state), 32'h400);
    press(1'b1, 1'b0, 9'h000);
    check("wr_st3_key0_ign", 32'(io.out_state), 32'h400);
    press(1'b0, 1'b1, 9'h0CC);
    check("wr_st4", 32'(io.out_state), 32'h800);
    io.memDone = 1'b1;
    press(1'b0, 1'b1, 9'h0CC);
    check("wr_wait", 32'(io.out_state), 32'h1000);
    check("wr_mode", 32'(io.modeOutput), 32'h2);
    check("wr_addr", 32'(io.memoryAddress), 32'h1FFFFFF);
    check("wr_data", 32'(io.writeData), 32'hCCCC);
    @(negedge clk);
    check("wr_dwell", 32'(io.out_state), 32'h1000);
    check("wr_dwell_done", 32'(io.ioDone), 32'h0);
    @(negedge clk);
    io.memDone = 1'b0;
    check("wr_exit_idle", 32'(io.out_state), 32'h002);
    check("wr_pulse", 32'(io.ioDone), 32'h1);
    check("wr_exit_mode", 32'(io.modeOutput), 32'h0);
    @(negedge clk);
    check("wr_pulse_end", 32'(io.ioDone), 32'h0);

    // abort in READ_ST1
    press(1'b1, 1'b0, 9'h000);
    press(1'b0, 1'b1, 9'h012);
    check("ab_rd_st1", 32'(io.out_state), 32'h008);
    press(1'b1, 1'b1, 9'h000);
    check("ab_rd_idle", 32'(io.out_state), 32'h002);
    check("ab_rd_addr", 32'(io.memoryAddress), 32'h1FFFF12);

    // abort in WRITE_WAIT with memDone low
    press(1'b1, 1'b0, 9'h100);
    press(1'b0, 1'b1, 9'h034);
    press(1'b0, 1'b1, 9'h056);
    press(1'b0, 1'b1, 9'h078);
    press(1'b0, 1'b1, 9'h011);
    press(1'b0, 1'b1, 9'h022);
    check("ab_wr_wait", 32'(io.out_state), 32'h1000);
    repeat (2) @(negedge clk);
    check("ab_wr_stuck", 32'(io.out_state), 32'h1000);
    press(1'b1, 1'b1, 9'h000);
    check("ab_wr_idle", 32'(io.out_state), 32'h002);
    check("ab_wr_mode", 32'(io.modeOutput), 32'h0);
    check("ab_wr_iodone", 32'(io.ioDone), 32'h0);
    check("ab_wr_addr", 32'(io.memoryAddress), 32'h0785634);
    check("ab_wr_data", 32'(io.writeData), 32'h2211);

    // async reset in the middle of WRITE_WAIT
    press(1'b1, 1'b0, 9'h100);
    press(1'b0, 1'b1, 9'h001);
    press(1'b0, 1'b1, 9'h002);
    press(1'b0, 1'b1, 9'h003);
    press(1'b0, 1'b1, 9'h044);
    press(1'b0, 1'b1, 9'h055);
    check("ar_wait", 32'(io.out_state), 32'h1000);
    check("ar_data_pre", 32'(io.writeData), 32'h5544);
    #2 reset = 1'b1;
    #1;
    check("ar_state", 32'(io.out_state), 32'h001);
    check("ar_mode", 32'(io.modeOutput), 32'h0);
    check("ar_data", 32'(io.writeData), 32'h0);
    check("ar_addr", 32'(io.memoryAddress), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ar_init_hold", 32'(io.out_state), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/in_out_control.md
Name: in_out_control

Overview:
- Front-panel I/O sequencer between board keys/switches and the memory controller.
- The user enters a 25-bit address, and for writes a 16-bit data word, in byte-sized chunks on sw, pressing key1 after each chunk.
- The block then issues a read or write request and waits for memDone.
- Read results are held on displayData; the current FSM state is exported one-hot on out_state.

Parameters:
- none (all widths fixed: address 25, data 16, switches 9, state vector 13).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- key0_pulse  in  1  single-cycle key0 press (start / acknowledge).
- key1_pulse  in  1  single-cycle key1 press (advance / capture).
- sw  in  9  slide switches; sw[8] selects operation in IDLE, sw[7:0] carries data bytes, sw[8:0] carries the address top chunk.
- memDone  in  1  memory controller ready/complete; low while busy.
- read_data  in  16  data returned by memory.
- modeOutput  out  2  request to memory: 00 none, 01 read, 10 write (11 unused).
- memoryAddress  out  25  assembled address register.
- writeData  out  16  assembled write data register.
- displayData  out  16  value for the seven-segment display.
- ioDone  out  1  operation-complete flag.
- out_state  out  13  one-hot current state (bit order = state list below).

Behaviour:
- Async reset: state=INIT; memoryAddress=0, writeData=0, displayData=0, modeOutput=00, ioDone=0.
- States, out_state bit index 0..12: INIT, IDLE, READ_ST0, READ_ST1, READ_ST2, READ_WAIT, READ_DONE, WRITE_ST0, WRITE_ST1, WRITE_ST2, WRITE_ST3, WRITE_ST4, WRITE_WAIT.
- Global priority rule: key0_pulse and key1_pulse high in the same cycle force IDLE from any state. This overrides every transition below. Registers are not cleared.
- INIT: waits only for the simultaneous-key event.
- IDLE (key0 alone):
  - sw[8]=0 → READ_ST0.
  - sw[8]=1 → WRITE_ST0.
  - key1 alone is ignored.
- Address capture, on key1 alone, each transition registered on the same edge:
  - ST0: memoryAddress[7:0] <= sw[7:0].
  - ST1: memoryAddress[15:8] <= sw[7:0].
  - ST2: memoryAddress[24:16] <= sw[8:0].
- Read path: READ_ST0 → READ_ST1 → READ_ST2 → READ_WAIT.
- Write path: WRITE_ST0 → WRITE_ST1 → WRITE_ST2 → WRITE_ST3.
  - WRITE_ST3, key1: writeData[7:0] <= sw[7:0] → WRITE_ST4.
  - WRITE_ST4, key1: writeData[15:8] <= sw[7:0] → WRITE_WAIT.
- Sequencer key handling:
  - key0 alone in any ST state is ignored.
  - Address bits not yet captured keep their previous values.
- READ_WAIT:
  - modeOutput=01 for the whole state.
  - Exits to READ_DONE on the first rising edge with memDone=1, evaluated from the second WAIT cycle onward (minimum WAIT dwell of 2 cycles).
  - Exit edge: displayData <= read_data.
- READ_DONE:
  - modeOutput=00, ioDone=1.
  - key0 alone → IDLE.
  - displayData holds.
- WRITE_WAIT:
  - modeOutput=10, same 2-cycle minimum dwell and memDone exit rule.
  - Exits to IDLE with a 1-cycle ioDone pulse in the first IDLE cycle.
- modeOutput is 00 in all states other than the two WAIT states.
- ioDone is 0 in all other cases.
- If memDone stays low forever, the FSM stays in WAIT. Only reset or the two-key abort leave WAIT; abort drops modeOutput to 00 on the next cycle.
- Outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

Test Plan:
- Reset, then key0+key1 together → out_state=13'h002 (IDLE); all data outputs 0.
- Read flow:
  - key0 with sw[8]=0.
  - key1 with sw=0FF, then 0FF, then 1FF → memoryAddress=25'h1FFFFFF.
  - READ_WAIT with modeOutput=01 while memDone=0.
  - read_data=16'hAAAA, raise memDone → READ_DONE, displayData=AAAA, ioDone=1.
  - key0 → IDLE.
- Write flow:
  - key0 with sw[8]=1.
  - Address 0FF, 0FF, 1FF, then data bytes 0CC, 0CC → memoryAddress=1FFFFFF, writeData=16'hCCCC.
  - WRITE_WAIT with modeOutput=10.
  - memDone=1 → IDLE, ioDone pulses exactly 1 cycle.
- Abort: in READ_ST1 and in WRITE_WAIT with memDone=0, press both keys → IDLE next cycle, modeOutput=00, captured registers unchanged.
- Ignored inputs: key1 in IDLE, key0 in READ_ST2 and WRITE_ST3 → no state change.
- Async reset asserted mid-WRITE_WAIT (between clock edges) → immediately INIT, modeOutput=00, writeData=0.
